// File: rtl/encoder_sample_ctrl_if.sv
// Sample output channel of the encoder sampling controller: signed window delta,
// saturation flag and a valid/ready handshake toward the velocity/telemetry consumer.
interface encoder_sample_ctrl_if #(
  parameter int unsigned DELTA_WIDTH = 16
);
  logic signed [DELTA_WIDTH-1:0] sample_delta;
  logic                          sample_sat;
  logic                          sample_valid;
  logic                          sample_ready;

  modport master (
    output sample_delta,
    output sample_sat,
    output sample_valid,
    input  sample_ready
  );

  modport slave (
    input  sample_delta,
    input  sample_sat,
    input  sample_valid,
    output sample_ready
  );
endinterface

// File: rtl/encoder_sample_ctrl.sv
// Windowed sampling controller: tracks a wrapping signed position from decoded
// quadrature steps and emits a saturating signed edge delta once per window.
module encoder_sample_ctrl #(
  parameter int unsigned POS_WIDTH    = 32,
  parameter int unsigned DELTA_WIDTH  = 16,
  parameter int unsigned PERIOD_WIDTH = 24
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic [PERIOD_WIDTH-1:0] period,
  input  logic                    step,
  input  logic                    step_dir,
  input  logic                    pos_clear,
  output logic [POS_WIDTH-1:0]    position,
  output logic                    overrun,
  input  logic                    overrun_clr,
  encoder_sample_ctrl_if.master   smp
);

  localparam logic signed [DELTA_WIDTH-1:0] ACC_MAX = {1'b0, {(DELTA_WIDTH-1){1'b1}}};
  localparam logic signed [DELTA_WIDTH-1:0] ACC_MIN = {1'b1, {(DELTA_WIDTH-1){1'b0}}};
  localparam logic signed [DELTA_WIDTH-1:0] D_ONE   = {{(DELTA_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [POS_WIDTH-1:0]          P_ONE   = {{(POS_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [PERIOD_WIDTH-1:0]       T_ONE   = {{(PERIOD_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t                        state_q, state_d;
  logic [PERIOD_WIDTH-1:0]       timer_q, timer_d;
  logic signed [DELTA_WIDTH-1:0] acc_q, acc_d, acc_stepped;
  logic                          sat_q, sat_d, clip;
  logic                          load, ovr_set, slot_free;

  always_ff @(posedge clk) begin
    if (rst) begin
      position <= '0;
    end else if (pos_clear) begin
      position <= '0;
    end else if (step) begin
      position <= step_dir ? position + P_ONE : position - P_ONE;
    end
  end

  // Accumulator with this cycle's step applied, clipped at the signed limits
  always_comb begin
    acc_stepped = acc_q;
    clip        = 1'b0;
    if (step) begin
      if (step_dir) begin
        if (acc_q == ACC_MAX) clip = 1'b1;
        else                  acc_stepped = acc_q + D_ONE;
      end else begin
        if (acc_q == ACC_MIN) clip = 1'b1;
        else                  acc_stepped = acc_q - D_ONE;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    acc_d     = acc_q;
    sat_d     = sat_q;
    load      = 1'b0;
    ovr_set   = 1'b0;
    slot_free = !smp.sample_valid || smp.sample_ready;
    case (state_q)
      IDLE: begin
        acc_d = '0;
        sat_d = 1'b0;
        if (enable && (period != '0)) begin
          state_d = RUN;
          timer_d = period - T_ONE;
        end
      end
      RUN: begin
        if (!enable) begin
          state_d = IDLE;
          timer_d = '0;
          acc_d   = '0;
          sat_d   = 1'b0;
        end else if (timer_q == '0) begin
          // A busy slot keeps the count so the next sample covers both windows
          if (slot_free) begin
            load  = 1'b1;
            acc_d = '0;
            sat_d = 1'b0;
          end else begin
            ovr_set = 1'b1;
            acc_d   = acc_stepped;
            sat_d   = sat_q | clip;
          end
          if (period == '0) begin
            state_d = IDLE;
            timer_d = '0;
          end else begin
            timer_d = period - T_ONE;
          end
        end else begin
          timer_d = timer_q - T_ONE;
          acc_d   = acc_stepped;
          sat_d   = sat_q | clip;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= IDLE;
      timer_q          <= '0;
      acc_q            <= '0;
      sat_q            <= 1'b0;
      smp.sample_delta <= '0;
      smp.sample_sat   <= 1'b0;
      smp.sample_valid <= 1'b0;
      overrun          <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      acc_q   <= acc_d;
      sat_q   <= sat_d;
      if (load) begin
        smp.sample_delta <= acc_stepped;
        smp.sample_sat   <= sat_q | clip;
        smp.sample_valid <= 1'b1;
      end else if (smp.sample_ready) begin
        smp.sample_valid <= 1'b0;
      end
      if (ovr_set)          overrun <= 1'b1;
      else if (overrun_clr) overrun <= 1'b0;
    end
  end

endmodule
